pcm_pingpong_buffer: RTL and testbench

Double-banked (ping-pong) capture buffer for 24-bit PCM samples from the I2S receiver. It collects BUFFER_DEPTH samples per bank and announces each full bank with a one-cycle `buffer_ready_o` pulse. It then streams the bank out over a ready/valid interface to the VU-meter consumer, while the other bank keeps filling. It sits directly upstream of the VU meter and provides the spacing that meter's WAIT/READING/COMPUTE/SETTLE sequencing requires.

---
 rtl/pcm_pingpong_buffer.sv | 149 ++++++++++++++
 tb/tb_pcm_pingpong_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_pingpong_buffer.sv
// Ping-pong capture of 24-bit PCM samples into two banks, each bank streamed out whole (optional drop counter: PCM_BUFFER_DROP_COUNT_EN).
// Latency: last capture on edge E -> buffer_ready_o E+1, first read_valid_o E+2; GAP_CYCLES idle after each bank.
// Backpressure: read side holds data/valid while !read_ready_i; samples arriving at a full bank are dropped and flagged.
module pcm_pingpong_buffer #(
    parameter int BUFFER_DEPTH = 16,
    parameter int GAP_CYCLES   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [23:0] sample_i,
    input  logic        sample_valid_i,
    output logic [23:0] read_data_o,
    output logic        read_valid_o,
    input  logic        read_ready_i,
    output logic        buffer_ready_o,
    output logic        overflow_o,
    output logic [1:0]  bank_full_o,
    output logic [15:0] drop_count_o
);
    localparam int IDX_W = $clog2(BUFFER_DEPTH);
    localparam int GAP_W = $clog2(GAP_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_DEPTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ANNOUNCE, ST_STREAM, ST_GAP} state_t;

    logic [23:0]      mem [2*BUFFER_DEPTH];
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       bank_full;
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rd_idx_nxt;
    logic [GAP_W-1:0] gap_cnt;
    state_t           state;

    logic wr_en, wr_last, drop, hs, rel;
    logic [1:0] full_set, full_clr;

    assign wr_en      = sample_valid_i && !bank_full[wr_bank];
    assign drop       = sample_valid_i &&  bank_full[wr_bank];
    assign wr_last    = wr_en && (wr_idx == LAST_IDX);
    assign hs         = read_valid_o && read_ready_i;
    assign rel        = hs && (rd_idx == LAST_IDX);
    assign rd_idx_nxt = rd_idx + 1'b1;
    // A bank can only be set while empty and only released while full, so set/clear never target the same bank.
    assign full_set   = {wr_bank, ~wr_bank} & {2{wr_last}};
    assign full_clr   = {rd_bank, ~rd_bank} & {2{rel}};
    assign bank_full_o = bank_full;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[{wr_bank, wr_idx}] <= sample_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            bank_full  <= 2'b00;
            overflow_o <= 1'b0;
        end else begin
            bank_full <= (bank_full | full_set) & ~full_clr;
            if (drop) begin
                overflow_o <= 1'b1;
            end
            if (wr_en) begin
                if (wr_idx == LAST_IDX) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_IDLE;
            rd_bank        <= 1'b0;
            rd_idx         <= '0;
            gap_cnt        <= '0;
            read_data_o    <= '0;
            read_valid_o   <= 1'b0;
            buffer_ready_o <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        state          <= ST_ANNOUNCE;
                        buffer_ready_o <= 1'b1;
                    end
                end
                ST_ANNOUNCE: begin
                    buffer_ready_o <= 1'b0;
                    read_valid_o   <= 1'b1;
                    read_data_o    <= mem[{rd_bank, rd_idx}];
                    state          <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (hs) begin
                        if (rd_idx == LAST_IDX) begin
                            read_valid_o <= 1'b0;
                            rd_bank      <= ~rd_bank;
                            rd_idx       <= '0;
                            gap_cnt      <= '0;
                            state        <= ST_GAP;
                        end else begin
                            rd_idx      <= rd_idx_nxt;
                            read_data_o <= mem[{rd_bank, rd_idx_nxt}];
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        if (bank_full[rd_bank]) begin
                            state          <= ST_ANNOUNCE;
                            buffer_ready_o <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PCM_BUFFER_DROP_COUNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign drop_count_o = drop_cnt;
`else
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_pcm_pingpong_buffer.sv
// Scoreboard bench for pcm_pingpong_buffer: fill/drain, backpressure, gap spacing, sign, overflow, async reset.
module tb_pcm_pingpong_buffer;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [23:0] sample_i = '0;
    logic        sample_valid_i = 1'b0;
    logic        read_ready_i = 1'b0;
    logic [23:0] read_data_o;
    logic        read_valid_o;
    logic        buffer_ready_o;
    logic        overflow_o;
    logic [1:0]  bank_full_o;
    logic [15:0] drop_count_o;

`ifdef PCM_BUFFER_DROP_COUNT_EN
    localparam logic [31:0] EXP_DROPS = 32'd8;
`else
    localparam logic [31:0] EXP_DROPS = 32'd0;
`endif

    pcm_pingpong_buffer #(.BUFFER_DEPTH(16), .GAP_CYCLES(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .read_data_o    (read_data_o),
        .read_valid_o   (read_valid_o),
        .read_ready_i   (read_ready_i),
        .buffer_ready_o (buffer_ready_o),
        .overflow_o     (overflow_o),
        .bank_full_o    (bank_full_o),
        .drop_count_o   (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [23:0] sb_q[$];
    int          hs_edge_q[$];
    int          br_edge_q[$];
    bit          bp_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_data = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs sampled on the falling edge; a handshake seen here completes on the next rising edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", 32'(read_valid_o), 32'd1);
                check_val("stall_data", 32'(read_data_o), 32'(prev_data));
            end
            if (buffer_ready_o) begin
                br_edge_q.push_back(cyc);
                check_val("br_vs_valid", 32'(read_valid_o), 32'd0);
            end
            if (read_valid_o && read_ready_i) begin
                hs_edge_q.push_back(cyc + 1);
                if (sb_q.size() == 0) check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
                else check_val("sb_data", 32'(read_data_o), 32'(sb_q.pop_front()));
            end
            prev_stall = read_valid_o && !read_ready_i;
            prev_data  = read_data_o;
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (bp_en) read_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] v);
        sample_i       = v;
        sample_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        sample_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check_val(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int hb, bb, e, n;
        logic [15:0] d0;
        logic [23:0] v;

        idle(3);
        check_val("rst_data", 32'(read_data_o), 32'd0);
        check_val("rst_valid", 32'(read_valid_o), 32'd0);
        check_val("rst_br", 32'(buffer_ready_o), 32'd0);
        check_val("rst_ovf", 32'(overflow_o), 32'd0);
        check_val("rst_full", 32'(bank_full_o), 32'd0);
        check_val("rst_drops", 32'(drop_count_o), 32'd0);
        rst_ni = 1'b1;
        idle(2);

        // Fill/drain with exact announce timing
        read_ready_i = 1'b1;
        hb = hs_edge_q.size();
        bb = br_edge_q.size();
        for (int i = 1; i <= 15; i++) begin
            sb_q.push_back(24'(i));
            send(24'(i));
            idle(3);
        end
        sb_q.push_back(24'd16);
        send(24'd16);
        e = cyc;
        check_val("t1_full_at_E", 32'(bank_full_o), 32'd1);
        check_val("t1_br_at_E", 32'(buffer_ready_o), 32'd0);
        idle(1);
        check_val("t1_br_E1", 32'(buffer_ready_o), 32'd1);
        check_val("t1_valid_E1", 32'(read_valid_o), 32'd0);
        idle(1);
        check_val("t1_br_E2", 32'(buffer_ready_o), 32'd0);
        check_val("t1_valid_E2", 32'(read_valid_o), 32'd1);
        wait_drain("t1_drain", 100);
        idle(8);
        check_val("t1_br_count", 32'(br_edge_q.size() - bb), 32'd1);
        if (br_edge_q.size() > bb) check_val("t1_br_edge", 32'(br_edge_q[bb]), 32'(e + 1));
        check_val("t1_hs_count", 32'(hs_edge_q.size() - hb), 32'd16);
        check_val("t1_full_end", 32'(bank_full_o), 32'd0);

        // Backpressure
        bp_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            sb_q.push_back(24'(i));
            send(24'(i));
            idle(3);
        end
        wait_drain("t2_drain", 400);
        bp_en = 1'b0;
        read_ready_i = 1'b1;
        idle(8);
        check_val("t2_full_end", 32'(bank_full_o), 32'd0);

        // Gap spacing with continuous input
        hb = hs_edge_q.size();
        bb = br_edge_q.size();
        d0 = drop_count_o;
        for (int i = 0; i < 32; i++) begin
            sb_q.push_back(24'(32'h200 + i));
            send(24'(32'h200 + i));
        end
        wait_drain("t3_drain", 200);
        idle(8);
        check_val("t3_br_count", 32'(br_edge_q.size() - bb), 32'd2);
        check_val("t3_hs_count", 32'(hs_edge_q.size() - hb), 32'd32);
        if (br_edge_q.size() > bb + 1 && hs_edge_q.size() > hb + 15)
            check_val("t3_gap", 32'(br_edge_q[bb + 1] - hs_edge_q[hb + 15]), 32'd4);
        check_val("t3_no_ovf", 32'(overflow_o), 32'd0);
        check_val("t3_no_drops", 32'(drop_count_o), 32'(d0));

        // Sign pass-through
        for (int i = 0; i < 16; i++) begin
            case (i)
                0: v = 24'h800000;
                1: v = 24'hFFFFFF;
                2: v = 24'h7FFFFF;
                default: v = 24'(32'h5A5A5A ^ (i * 32'h111111));
            endcase
            sb_q.push_back(v);
            send(v);
            idle(1);
        end
        wait_drain("t4_drain", 100);
        idle(8);

        // Overflow with consumer stalled
        read_ready_i = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i <= 32) sb_q.push_back(24'(i));
            send(24'(i));
        end
        check_val("t5_full", 32'(bank_full_o), 32'd3);
        check_val("t5_ovf", 32'(overflow_o), 32'd1);
        check_val("t5_drops", 32'(drop_count_o), EXP_DROPS);
        read_ready_i = 1'b1;
        wait_drain("t5_drain", 300);
        idle(8);
        check_val("t5_full_end", 32'(bank_full_o), 32'd0);

        // Async reset mid-stream
        hb = hs_edge_q.size();
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(24'(32'h300 + i));
            send(24'(32'h300 + i));
        end
        n = 0;
        while (hs_edge_q.size() < hb + 5 && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check_val("t6_reached_hs5", 32'(hs_edge_q.size() - hb), 32'd5);
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("t6_valid", 32'(read_valid_o), 32'd0);
        check_val("t6_br", 32'(buffer_ready_o), 32'd0);
        check_val("t6_full", 32'(bank_full_o), 32'd0);
        check_val("t6_ovf", 32'(overflow_o), 32'd0);
        check_val("t6_data", 32'(read_data_o), 32'd0);
        sb_q.delete();
        idle(2);
        rst_ni = 1'b1;
        idle(2);
        hb = hs_edge_q.size();
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(24'(32'h400 + i));
            send(24'(32'h400 + i));
            idle(1);
        end
        wait_drain("t6_drain", 100);
        idle(8);
        check_val("t6_hs_count", 32'(hs_edge_q.size() - hb), 32'd16);
        check_val("t6_full_end", 32'(bank_full_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
